// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ producers share one downstream fifo write port.
// Define FIFO_WR_ARBITER_STATS_EN to build the per-requester accepted-beat counters.
//
// state | meaning
// IDLE  | no owner; picks the next requester after last_owner
// BURST | one owner streams up to MAX_BURST beats into the fifo
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*WIDTH-1:0]     req_data,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       fifo_full,
   output logic                       fifo_wr,
   output logic [WIDTH-1:0]           fifo_wr_data,
   output logic                       grant_valid,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   input  logic                       stats_clr,
   output logic [N_REQ*16-1:0]        grant_count
);

   localparam int             ID_W      = $clog2(N_REQ);
   localparam logic [3:0]     LAST_BEAT = 4'(MAX_BURST - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   owner, owner_nxt;
   logic [ID_W-1:0]   last_owner, last_nxt;
   logic [3:0]        beat_cnt, beat_nxt;
   logic [ID_W-1:0]   pick;
   logic              xfer;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= ID_W'(N_REQ - 1);
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_nxt;
         beat_cnt   <= beat_nxt;
      end
   end

   // Search upward from last_owner+1, wrapping; last_owner itself is checked last.
   always_comb begin
      logic found;
      int   idx;
      pick  = last_owner;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = (int'(last_owner) + i) % N_REQ;
         if (!found && req_valid[ID_W'(idx)]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      last_nxt     = last_owner;
      beat_nxt     = beat_cnt;
      req_ready    = '0;
      xfer         = 1'b0;
      fifo_wr      = 1'b0;
      fifo_wr_data = '0;
      grant_valid  = 1'b0;
      grant_id     = '0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               state_nxt = BURST;
               owner_nxt = pick;
               beat_nxt  = '0;
            end
         end
         BURST: begin
            grant_valid      = 1'b1;
            grant_id         = owner;
            req_ready[owner] = !fifo_full;
            xfer             = req_valid[owner] & !fifo_full;
            fifo_wr          = xfer;
            fifo_wr_data     = req_data[int'(owner)*WIDTH +: WIDTH];
            if (!req_valid[owner]) begin
               state_nxt = IDLE;
               last_nxt  = owner;
            end else if (xfer) begin
               beat_nxt = beat_cnt + 4'd1;
               if (beat_cnt == LAST_BEAT) begin
                  state_nxt = IDLE;
                  last_nxt  = owner;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FIFO_WR_ARBITER_STATS_EN
   logic [N_REQ-1:0][15:0] cnt;

   // Clear wins over a same-cycle increment; counters stick at 16'hFFFF.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (stats_clr)
               cnt[i] <= '0;
            else if (xfer && owner == ID_W'(i) && cnt[i] != 16'hFFFF)
               cnt[i] <= cnt[i] + 16'd1;
         end
      end
   end

   assign grant_count = cnt;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
   assign grant_count      = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table plus a write scoreboard.
module tb_fifo_wr_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     req_ready;
   logic             fifo_full = 1'b0;
   logic             fifo_wr;
   logic [W-1:0]     fifo_wr_data;
   logic             grant_valid;
   logic [1:0]       grant_id;
   logic             stats_clr = 1'b0;
   logic [N*16-1:0]  grant_count;

   int tests = 0;
   int fails = 0;

   logic [3:0] beat_idx [N] = '{default: '0};
   int         exp_idx  [N] = '{default: 0};
   int         exp_cnt  [N] = '{default: 0};

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0] valid;
      logic       full;
      logic       gv;
      logic [1:0] id;
      logic       wr;
      logic [3:0] ready;
      int         push_id;
      int         push_n;
   } vec_t;
   vec_t vec[$];

   always #5 clk = ~clk;

   always_comb
      for (int i = 0; i < N; i++) req_data[i*W +: W] = {4'(i), beat_idx[i]};

   fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(4)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr      (fifo_wr),
      .fifo_wr_data (fifo_wr_data),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id),
      .stats_clr    (stats_clr),
      .grant_count  (grant_count)
   );

`ifdef FIFO_WR_ARBITER_STATS_EN
   logic          reset2_n = 1'b0;
   logic [1:0]    valid2 = '0;
   logic [15:0]   data2 = '0;
   logic [1:0]    ready2;
   logic          wr2;
   logic [7:0]    wr_data2;
   logic          gv2;
   logic          id2;
   logic          clr2 = 1'b0;
   logic [31:0]   count2;

   fifo_wr_arbiter #(.N_REQ(2), .WIDTH(8), .MAX_BURST(16)) dut_sat (
      .clk          (clk),
      .reset_n      (reset2_n),
      .req_valid    (valid2),
      .req_data     (data2),
      .req_ready    (ready2),
      .fifo_full    (1'b0),
      .fifo_wr      (wr2),
      .fifo_wr_data (wr_data2),
      .grant_valid  (gv2),
      .grant_id     (id2),
      .stats_clr    (clr2),
      .grant_count  (count2)
   );
`endif

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_beats(input int id, input int n);
      for (int k = 0; k < n; k++) begin
         sb.push_back('{2'(id), {4'(id), 4'(exp_idx[id])}});
         exp_idx[id]++;
         exp_cnt[id]++;
      end
   endtask

   function automatic logic [N*16-1:0] exp_counts();
      logic [N*16-1:0] r = '0;
`ifdef FIFO_WR_ARBITER_STATS_EN
      for (int i = 0; i < N; i++) r[i*16 +: 16] = 16'(exp_cnt[i]);
`endif
      return r;
   endfunction

   task automatic add(input int reps, input logic [3:0] v, input logic f, input logic gv,
                      input logic [1:0] id, input logic wr, input logic [3:0] rdy,
                      input int pid = 0, input int pn = 0);
      for (int k = 0; k < reps; k++)
         vec.push_back('{v, f, gv, id, wr, rdy, pid, (k == 0) ? pn : 0});
   endtask

   // Write monitor: invariants every cycle, scoreboard pop on each fifo write.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n) begin
         check("wr_while_full", 64'(fifo_wr & fifo_full), 64'd0);
         check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
         if (fifo_wr) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_wr: got write id %0d data %0h, expected none", grant_id, fifo_wr_data);
            end else begin
               e = sb.pop_front();
               check("wr_id", 64'(grant_id), 64'(e.id));
               check("wr_data", 64'(fifo_wr_data), 64'(e.data));
            end
         end
         for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) beat_idx[i] = beat_idx[i] + 4'd1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      //   reps valid   full gv id wr ready   push
      add(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 0, 4);
      add(4, 4'b1111, 0, 1, 0, 1, 4'b0001);
      add(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 1, 4);
      add(4, 4'b1111, 0, 1, 1, 1, 4'b0010);
      add(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 2, 4);
      add(4, 4'b1111, 0, 1, 2, 1, 4'b0100);
      add(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 3, 4);
      add(4, 4'b1111, 0, 1, 3, 1, 4'b1000);
      add(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 0, 4);
      add(4, 4'b1111, 0, 1, 0, 1, 4'b0001);
      add(1, 4'b0000, 0, 0, 0, 0, 4'b0000);
      // owner 1 drops after two beats; 0011 then goes to 0
      add(1, 4'b0010, 0, 0, 0, 0, 4'b0000, 1, 2);
      add(2, 4'b0010, 0, 1, 1, 1, 4'b0010);
      add(1, 4'b0001, 0, 1, 1, 0, 4'b0010);
      add(1, 4'b0011, 0, 0, 0, 0, 4'b0000, 0, 4);
      add(4, 4'b0011, 0, 1, 0, 1, 4'b0001);
      add(1, 4'b0000, 0, 0, 0, 0, 4'b0000);
      // requester 2 stalled by fifo_full for 3 cycles mid-burst
      add(1, 4'b0100, 0, 0, 0, 0, 4'b0000, 2, 4);
      add(2, 4'b0100, 0, 1, 2, 1, 4'b0100);
      add(3, 4'b0100, 1, 1, 2, 0, 4'b0000);
      add(2, 4'b0100, 0, 1, 2, 1, 4'b0100);
      add(1, 4'b0000, 0, 0, 0, 0, 4'b0000);
      // wrap 3 -> 0; non-owner toggling has no effect
      add(1, 4'b1000, 0, 0, 0, 0, 4'b0000, 3, 4);
      add(4, 4'b1000, 0, 1, 3, 1, 4'b1000);
      add(1, 4'b1001, 0, 0, 0, 0, 4'b0000, 0, 4);
      add(1, 4'b1001, 0, 1, 0, 1, 4'b0001);
      add(1, 4'b0001, 0, 1, 0, 1, 4'b0001);
      add(1, 4'b1001, 0, 1, 0, 1, 4'b0001);
      add(1, 4'b0001, 0, 1, 0, 1, 4'b0001);
      add(1, 4'b0000, 0, 0, 0, 0, 4'b0000);

      // reset state, with requests pending
      reset_n   = 1'b0;
      req_valid = 4'b1111;
      #2;
      check("rst_gv", 64'(grant_valid), 64'd0);
      check("rst_id", 64'(grant_id), 64'd0);
      check("rst_wr", 64'(fifo_wr), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_data", 64'(fifo_wr_data), 64'd0);
      check("rst_count", grant_count, 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;

      for (int k = 0; k < vec.size(); k++) begin
         req_valid = vec[k].valid;
         fifo_full = vec[k].full;
         if (vec[k].push_n > 0) push_beats(vec[k].push_id, vec[k].push_n);
         @(negedge clk);
         check($sformatf("v%0d_gv", k), 64'(grant_valid), 64'(vec[k].gv));
         check($sformatf("v%0d_id", k), 64'(grant_id), 64'(vec[k].id));
         check($sformatf("v%0d_wr", k), 64'(fifo_wr), 64'(vec[k].wr));
         check($sformatf("v%0d_ready", k), 64'(req_ready), 64'(vec[k].ready));
         @(posedge clk); #1;
      end
      check("sb_drained_a", 64'(sb.size()), 64'd0);
      check("count_a", grant_count, exp_counts());

      stats_clr = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b0;
      for (int i = 0; i < N; i++) exp_cnt[i] = 0;
      check("count_clr", grant_count, exp_counts());

      // reset mid-burst: owner 3 presenting beat 2
      req_valid = 4'b1000;
      push_beats(3, 2);
      @(negedge clk);
      check("mr_idle_gv", 64'(grant_valid), 64'd0);
      for (int b = 0; b < 2; b++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("mr_gv", 64'(grant_valid), 64'd1);
         check("mr_id", 64'(grant_id), 64'd3);
      end
      @(posedge clk); #1;
      check("mr_b2_wr", 64'(fifo_wr), 64'd1);
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) exp_cnt[i] = 0;
      #1;
      check("mr_rst_wr", 64'(fifo_wr), 64'd0);
      check("mr_rst_gv", 64'(grant_valid), 64'd0);
      check("mr_rst_ready", 64'(req_ready), 64'd0);
      check("mr_rst_count", grant_count, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      push_beats(3, 4);
      @(negedge clk);
      check("mr_rel_gv", 64'(grant_valid), 64'd0);
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("mr_re_id", 64'(grant_id), 64'd3);
         check("mr_re_wr", 64'(fifo_wr), 64'd1);
      end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      check("mr_end_gv", 64'(grant_valid), 64'd0);
      check("sb_drained_b", 64'(sb.size()), 64'd0);
      check("count_b", grant_count, exp_counts());

`ifdef FIFO_WR_ARBITER_STATS_EN
      begin
         int beats = 0;
         int cyc   = 0;
         @(posedge clk); #1;
         reset2_n = 1'b1;
         valid2   = 2'b01;
         while (beats < 70000 && cyc < 80000) begin
            @(negedge clk);
            if (wr2) beats++;
            cyc++;
         end
         valid2 = 2'b00;
         check("sat_beats", 64'(beats), 64'd70000);
         @(posedge clk); #1;
         check("sat_count0", 64'(count2[15:0]), 64'hFFFF);
         check("sat_count1", 64'(count2[31:16]), 64'd0);
         valid2 = 2'b01;
         cyc = 0;
         @(negedge clk);
         while (!wr2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
         end
         check("clr_on_xfer", 64'(wr2), 64'd1);
         clr2 = 1'b1;
         @(posedge clk); #1;
         clr2   = 1'b0;
         valid2 = 2'b00;
         check("clr_wins", 64'(count2[15:0]), 64'd0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of write requesters; legal range 2..8.
REQ-002 Parameter WIDTH, default 8, data width in bits, matching the downstream fifo WIDTH.
REQ-003 Parameter MAX_BURST, default 4, maximum accepted beats per grant; legal range 1..16.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  N_REQ  per-requester write request; bit i belongs to requester i.
REQ-007 req_data  input  N_REQ*WIDTH  per-requester write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  N_REQ  per-requester accept; a beat transfers when req_valid[i] and req_ready[i] are both 1.
REQ-009 fifo_full  input  1  full flag from the downstream fifo.
REQ-010 fifo_wr  output  1  write enable to the downstream fifo.
REQ-011 fifo_wr_data  output  WIDTH  write data to the downstream fifo.
REQ-012 grant_valid  output  1  high while a requester owns the grant.
REQ-013 grant_id  output  $clog2(N_REQ)  index of the current owner; 0 when grant_valid=0.
REQ-014 stats_clr  input  1  synchronous clear of the grant counters.
REQ-015 grant_count  output  N_REQ*16  per-requester accepted-beat counters; requester i occupies bits [i*16 +: 16].

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE (no owner) and BURST (one owner).
REQ-017 IDLE: if any req_valid bit is 1, the FSM SHALL enter BURST on the next edge, with owner = first set req_valid bit searching upward from (last_owner+1) mod N_REQ and wrapping; otherwise it SHALL stay in IDLE.
REQ-018 In IDLE, req_ready SHALL be all zeros and fifo_wr SHALL be 0.
REQ-019 In BURST, req_ready[owner] SHALL equal !fifo_full (combinational), and all other req_ready bits SHALL be 0.
REQ-020 fifo_wr SHALL equal req_valid[owner] & req_ready[owner] in the same cycle; fifo_wr_data SHALL equal the owner's req_data slice (zero-cycle latency).
REQ-021 fifo_wr SHALL never be 1 while fifo_full=1, whatever the read activity on the fifo.
REQ-022 A 4-bit beat counter SHALL load 0 on BURST entry and increment on each transfer.
REQ-023 BURST->IDLE SHALL occur on a transfer while beat_cnt==MAX_BURST-1, or on any cycle where req_valid[owner]==0; on either exit, last_owner SHALL load the owner.
REQ-024 fifo_full=1 during BURST SHALL stall without releasing: the grant is held and beat_cnt is unchanged.
REQ-025 A requester deasserting req_valid while not granted SHALL have no effect on the FSM or on last_owner.
REQ-026 Each release SHALL be followed by exactly one IDLE cycle before the next grant, so consecutive grants are separated by one bubble cycle.
REQ-027 Round-robin SHALL guarantee that a continuously requesting requester is granted within N_REQ-1 intervening grants.

Reset
REQ-028 On reset_n=0 the block SHALL asynchronously force: FSM=IDLE, last_owner=N_REQ-1 (so requester 0 wins first), beat_cnt=0, grant_valid=0, grant_id=0, req_ready=0, fifo_wr=0, fifo_wr_data=0, grant_count=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst; a beat is not transferred in a cycle where reset_n=0.
REQ-030 After reset_n deasserts, the first grant SHALL be possible on the first clock edge.

Configuration
REQ-031 Macro FIFO_WR_ARBITER_STATS_EN SHALL control the grant counters.
REQ-032 With FIFO_WR_ARBITER_STATS_EN defined: grant_count[i] SHALL increment by 1 per transfer by requester i, saturate at 16'hFFFF, and clear to 0 on stats_clr=1; stats_clr SHALL take precedence over an increment in the same cycle.
REQ-033 Without FIFO_WR_ARBITER_STATS_EN: grant_count SHALL be tied to 0, stats_clr SHALL be ignored, and no counter flops SHALL be implemented.

Verification
REQ-034 After reset, req_valid=4'b1111 held, fifo_full=0, MAX_BURST=4: grant order SHALL be 0,1,2,3,0; each grant SHALL carry 4 fifo_wr beats followed by 1 IDLE cycle.
REQ-035 Requester 2 alone, burst of 4 beats with fifo_full=1 during beats 2-3 for 3 cycles: grant_id SHALL stay 2, fifo_wr SHALL be 0 for those 3 cycles, and the burst SHALL complete with exactly 4 writes.
REQ-036 Requester 1 drops req_valid after 2 beats: the FSM SHALL return to IDLE the same cycle; the next grant with req_valid=4'b0011 SHALL go to requester 0.
REQ-037 reset_n pulsed low mid-burst (owner 3, beat 2): fifo_wr and grant_valid SHALL go 0 immediately; the first grant after release with req_valid=4'b1000 SHALL go to 3 with beat_cnt=0.
REQ-038 STATS_EN build: 70000 beats from requester 0 SHALL leave grant_count[0]=16'hFFFF; then stats_clr=1 for 1 cycle SHALL give 0.
REQ-039 All scenarios: assertion checks that fifo_wr&fifo_full is never 1 and that req_ready is one-hot or zero.
